uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered 8N1 UART transmitter: the send-side counterpart of the board's UART receive path.
- Accepts bytes from the memory-mapped peripheral block through a single-cycle push strobe and queues them in a small FIFO.
- Serialises queued bytes on `tx` at a fixed baud rate, back-to-back with no idle gap.
- Reports FIFO level, busy, a per-frame done pulse and a sticky overflow flag, so software can stream strings without polling every byte.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s. Baud divisor DIV = CLK_FREQ/BAUD, integer division; DIV must be ≥ 2.
- FIFO_DEPTH, 16, FIFO entries; must be a power of two.
- FIFO_DEPTH_BIT, 4, log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  push strobe; one byte pushed per high cycle.
- wr_data  input  8  byte to push, sampled when wr_en=1.
- clr_ovf  input  1  clears overflow; 1-cycle pulse.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is on the line (state≠IDLE).
- tx_done  output  1  1-cycle pulse in the last cycle of each stop bit.
- full  output  1  count==FIFO_DEPTH.
- empty  output  1  count==0.
- count  output  FIFO_DEPTH_BIT+1  number of queued bytes, excluding the byte in flight.
- overflow  output  1  sticky; set when a push is dropped.

Behaviour:
- Clock/reset: reset is asynchronous, active-high; clock is clk. Reset values: tx=1, busy=0, tx_done=0, full=0, empty=1, count=0, overflow=0, FSM=IDLE, pointers=0, baud counter=0.
- Reset mid-frame: frame aborted, tx returns high immediately (asynchronously), queued data discarded, no tx_done.
- Push:
  - wr_en=1 and full=0 → write at wr_ptr; wr_ptr+1, wrapping modulo FIFO_DEPTH.
  - wr_en=1 and full=1 → byte dropped, overflow←1. Full is evaluated before any same-cycle pop, so a push is dropped even if a pop occurs that cycle.
- Pop: performed only by the FSM (see below); rd_ptr+1 modulo FIFO_DEPTH.
- Simultaneous accepted push and pop: count unchanged.
- count, full, empty: registered, updated the cycle after the push/pop.
- overflow/clr_ovf conflict: clr_ovf has priority when both a clear and a drop occur in the same cycle (overflow reads 0 afterwards).
- FSM states: IDLE, START, DATA, STOP. Every non-IDLE state holds each bit for exactly DIV cycles, timed by a baud counter 0..DIV-1.
  - IDLE: tx=1. If empty=0: pop head into the shift register, clear baud counter, go to START.
  - START: tx=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] (LSB first). Shift right every DIV cycles; after bit index 7 go to STOP.
  - STOP: tx=1 for DIV cycles. On the last cycle assert tx_done. Then if empty=0, pop and go directly to START (zero idle gap); else go to IDLE.
- tx is driven from a register (glitch-free).
- Latency: wr_en at cycle N into an empty, idle block → empty=0 at N+1 → pop at N+1 → tx falls at N+2.
- Frame length: exactly 10·DIV cycles. tx_done is high at cycle N+1+10·DIV relative to that push.
- Width rules: pointers are FIFO_DEPTH_BIT bits wide; count is FIFO_DEPTH_BIT+1 bits; the baud counter is $clog2(DIV) bits with no overflow past DIV-1.

Decomposition:
- Package uart_pkg:
  - DATA_BITS=8.
  - FSM state typedef/localparams: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - Function computing DIV from CLK_FREQ and BAUD.
- Sub-module sync_fifo:
  - Parameters: width 8, depth FIFO_DEPTH.
  - Ports: push/pop/full/empty/count, with the drop-on-full rule above.
- The top level holds the baud counter, FSM, shift register and overflow flag.

Test Plan (CLK_FREQ=1600, BAUD=100 → DIV=16, FIFO_DEPTH=4, FIFO_DEPTH_BIT=2 unless noted):
- Reset: assert reset for 3 cycles mid-simulation → tx=1, empty=1, full=0, count=0, busy=0, overflow=0, all asynchronously.
- Single byte: push 0xA5 at cycle N → tx=0 over N+2..N+17; data bits 1,0,1,0,0,1,0,1, 16 cycles each; stop high; tx_done single pulse at N+161; busy=0 at N+162.
- Back-to-back: push 0x55 then 0x0F on consecutive cycles → second start bit begins the cycle after the first stop bit ends; 320 cycles continuous; two tx_done pulses exactly 160 cycles apart.
- Overflow: push 5 bytes in 5 consecutive cycles from idle → first popped, 4 queued, full=1, count=4; 6th push dropped, overflow=1, count stays 4; clr_ovf pulse → overflow=0; transmitted sequence excludes the dropped byte.
- Simultaneous push/pop: count=2 at the end of a STOP bit, push 0x3C in the pop cycle → count remains 2; 0x3C is sent last.
- Reset mid-frame: assert reset during data bit 3 of 0xFF with 2 bytes queued → tx=1 immediately, count=0, no tx_done, no further frames after reset release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: frame geometry,
// FSM state encoding and the baud divisor helper.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-side bus of the UART transmitter: push strobe, overflow clear and
// line/status outputs. The design is the slave, the host the master.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH_BIT = 4
) ();

  logic                    wr_en;
  logic [7:0]              wr_data;
  logic                    clr_ovf;
  logic                    tx;
  logic                    busy;
  logic                    tx_done;
  logic                    full;
  logic                    empty;
  logic [FIFO_DEPTH_BIT:0] count;
  logic                    overflow;

  modport master (
    output wr_en, wr_data, clr_ovf,
    input  tx, busy, tx_done, full, empty, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf,
    output tx, busy, tx_done, full, empty, count, overflow
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered level flags. A push while full is
// dropped and reported on drop_o so the owner can keep a sticky flag.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH     = DATA_BITS,
  parameter int DEPTH     = 16,
  parameter int DEPTH_BIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     push_data_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     pop_data_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [DEPTH_BIT:0]   count_o,
  output logic                 drop_o
);

  localparam logic [DEPTH_BIT:0]   CNT_FULL = (DEPTH_BIT+1)'(DEPTH);
  localparam logic [DEPTH_BIT:0]   CNT_ZERO = (DEPTH_BIT+1)'(0);
  localparam logic [DEPTH_BIT:0]   CNT_ONE  = (DEPTH_BIT+1)'(1);
  localparam logic [DEPTH_BIT-1:0] PTR_ONE  = DEPTH_BIT'(1);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [DEPTH_BIT-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BIT-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BIT:0]   count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 push_ok_s;
  logic                 pop_ok_s;

  // Full is the registered flag, so a push is judged before any same-cycle pop.
  assign push_ok_s  = push_i & ~full_q;
  assign pop_ok_s   = pop_i & ~empty_q;
  assign drop_o     = push_i & full_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign count_o    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == CNT_ZERO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {DEPTH_BIT{1'b0}};
      rd_ptr_q <= {DEPTH_BIT{1'b0}};
      count_q  <= CNT_ZERO;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: queues pushed bytes and sends them
// back-to-back, LSB first, each bit held for CLK_FREQ/BAUD cycles.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ       = 100000000,
  parameter int BAUD           = 9600,
  parameter int FIFO_DEPTH     = 16,
  parameter int FIFO_DEPTH_BIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ovf_q, ovf_d;
  logic                   pop_s;
  logic                   cnt_last_s;
  logic [DATA_BITS-1:0]   fifo_data_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic                   fifo_drop_s;
  logic [FIFO_DEPTH_BIT:0] fifo_count_s;

  sync_fifo #(
    .WIDTH     (DATA_BITS),
    .DEPTH     (FIFO_DEPTH),
    .DEPTH_BIT (FIFO_DEPTH_BIT)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (bus.wr_en),
    .push_data_i (bus.wr_data),
    .pop_i       (pop_s),
    .pop_data_o  (fifo_data_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count_s),
    .drop_o      (fifo_drop_s)
  );

  assign cnt_last_s = (cnt_q == CNT_MAX);

  // Frame sequencer; STOP pops the next byte directly so frames abut.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_data_s;
          cnt_d   = CNT_ZERO;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_last_s) begin
          cnt_d   = CNT_ZERO;
          idx_d   = IDX_ZERO;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_last_s) begin
          cnt_d   = CNT_ZERO;
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_last_s) begin
          cnt_d = CNT_ZERO;
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shift_d = fifo_data_s;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = CNT_ZERO;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from next state so they leave flops aligned with it.
  always_comb begin
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (cnt_d == CNT_MAX);
    if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end else if (fifo_drop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      idx_q   <= IDX_ZERO;
      shift_q <= {DATA_BITS{1'b0}};
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.tx_done  = done_q;
  assign bus.full     = fifo_full_s;
  assign bus.empty    = fifo_empty_s;
  assign bus.count    = fifo_count_s;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: pushed bytes are queued as expected
// frames and a line monitor decodes tx and compares each completed frame.
module tb_uart_tx_fifo;

  localparam int DIV = 16;

  logic clk;
  logic reset;

  uart_tx_fifo_if #(.FIFO_DEPTH_BIT(2)) bus ();

  uart_tx_fifo #(
    .CLK_FREQ       (1600),
    .BAUD           (100),
    .FIFO_DEPTH     (4),
    .FIFO_DEPTH_BIT (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q [$];
  int         frames_seen = 0;
  int         done_cnt    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line monitor: decode each frame by bit centres and score it.
  initial begin : monitor
    logic       prev_tx;
    bit         in_frame;
    int         fpos;
    logic [7:0] rx;
    logic [7:0] exp_b;
    prev_tx  = 1'b1;
    in_frame = 1'b0;
    fpos     = 0;
    rx       = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_frame = 1'b0;
        prev_tx  = 1'b1;
      end else begin
        if (bus.tx_done) done_cnt++;
        if (!in_frame) begin
          if (prev_tx && !bus.tx) begin
            in_frame = 1'b1;
            fpos     = 0;
            frames_seen++;
          end
        end else begin
          fpos++;
        end
        if (in_frame) begin
          if (fpos == DIV / 2) check("start_bit", {31'd0, bus.tx}, 32'd0);
          if (fpos >= 24 && fpos < 152 && ((fpos - 24) % DIV) == 0)
            rx[(fpos - 24) / DIV] = bus.tx;
          if (fpos == 152) check("stop_bit", {31'd0, bus.tx}, 32'd1);
          if (fpos == 158) check("tx_done_early", {31'd0, bus.tx_done}, 32'd0);
          if (fpos == 159) begin
            check("tx_done_at_frame_end", {31'd0, bus.tx_done}, 32'd1);
            if (exp_q.size() == 0) begin
              check("unexpected_frame", {24'd0, rx}, 32'hFFFF_FFFF);
            end else begin
              exp_b = exp_q.pop_front();
              check("rx_byte", {24'd0, rx}, {24'd0, exp_b});
            end
            in_frame = 1'b0;
          end
        end
        prev_tx = bus.tx;
      end
    end
  end

  task automatic push(input logic [7:0] b, input bit expect_it);
    if (expect_it) exp_q.push_back(b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tx_done && n < 400);
    check("tx_done_seen", {31'd0, bus.tx_done}, 32'd1);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    int base_done;
    int base_frames;
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, bus.tx}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.tx_done}, 32'd0);
    check("rst_full", {31'd0, bus.full}, 32'd0);
    check("rst_empty", {31'd0, bus.empty}, 32'd1);
    check("rst_count", {29'd0, bus.count}, 32'd0);
    check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single byte: latency, frame length, done pulse, busy release
    push(8'hA5, 1'b1);
    check("single_count_n1", {29'd0, bus.count}, 32'd1);
    check("single_empty_n1", {31'd0, bus.empty}, 32'd0);
    check("single_tx_n1", {31'd0, bus.tx}, 32'd1);
    @(negedge clk);
    check("single_tx_n2", {31'd0, bus.tx}, 32'd0);
    check("single_busy_n2", {31'd0, bus.busy}, 32'd1);
    check("single_count_n2", {29'd0, bus.count}, 32'd0);
    wait_done(n);
    check("single_done_latency", n, 32'd159);
    @(negedge clk);
    check("single_busy_end", {31'd0, bus.busy}, 32'd0);
    check("single_done_pulse", {31'd0, bus.tx_done}, 32'd0);
    check("single_done_count", done_cnt, 32'd1);
    repeat (5) @(negedge clk);

    // back-to-back frames
    push(8'h55, 1'b1);
    push(8'h0F, 1'b1);
    wait_done(n);
    check("b2b_first_done", n, 32'd159);
    wait_done(n);
    check("b2b_done_gap", n, 32'd160);
    @(negedge clk);
    check("b2b_busy_end", {31'd0, bus.busy}, 32'd0);
    check("b2b_frames", frames_seen, 32'd3);
    repeat (5) @(negedge clk);

    // overflow, clear, and clear-wins-over-drop
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    push(8'h44, 1'b1);
    push(8'h55, 1'b1);
    check("ovf_full", {31'd0, bus.full}, 32'd1);
    check("ovf_count4", {29'd0, bus.count}, 32'd4);
    check("ovf_not_yet", {31'd0, bus.overflow}, 32'd0);
    push(8'h66, 1'b0);
    check("ovf_set", {31'd0, bus.overflow}, 32'd1);
    check("ovf_count_hold", {29'd0, bus.count}, 32'd4);
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    check("ovf_cleared", {31'd0, bus.overflow}, 32'd0);
    bus.clr_ovf = 1'b1;
    push(8'h77, 1'b0);
    bus.clr_ovf = 1'b0;
    check("ovf_clear_priority", {31'd0, bus.overflow}, 32'd0);
    check("ovf_count_after", {29'd0, bus.count}, 32'd4);
    for (int i = 0; i < 5; i++) wait_done(n);
    @(negedge clk);
    check("ovf_drain_empty", {31'd0, bus.empty}, 32'd1);
    check("ovf_drain_busy", {31'd0, bus.busy}, 32'd0);
    repeat (5) @(negedge clk);

    // push in the same cycle as the STOP-end pop
    push(8'h81, 1'b1);
    push(8'h42, 1'b1);
    push(8'h18, 1'b1);
    check("simul_count_pre", {29'd0, bus.count}, 32'd2);
    wait_done(n);
    check("simul_count_at_pop", {29'd0, bus.count}, 32'd2);
    push(8'h3C, 1'b1);
    check("simul_count_after", {29'd0, bus.count}, 32'd2);
    for (int i = 0; i < 3; i++) wait_done(n);
    @(negedge clk);
    check("simul_drain_empty", {31'd0, bus.empty}, 32'd1);
    repeat (5) @(negedge clk);

    // reset during data bit 3 of 0xFF with two bytes queued
    push(8'hFF, 1'b0);
    push(8'h01, 1'b0);
    push(8'h02, 1'b0);
    check("mid_count_pre", {29'd0, bus.count}, 32'd2);
    repeat (70) @(negedge clk);
    check("mid_busy_pre", {31'd0, bus.busy}, 32'd1);
    base_done = done_cnt;
    #3 reset = 1'b1;
    #1;
    check("mid_rst_tx", {31'd0, bus.tx}, 32'd1);
    check("mid_rst_count", {29'd0, bus.count}, 32'd0);
    check("mid_rst_empty", {31'd0, bus.empty}, 32'd1);
    check("mid_rst_full", {31'd0, bus.full}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_ovf", {31'd0, bus.overflow}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    base_frames = frames_seen;
    repeat (400) @(negedge clk);
    check("mid_no_done", done_cnt, base_done);
    check("mid_no_frames", frames_seen, base_frames);
    check("mid_idle_tx", {31'd0, bus.tx}, 32'd1);
    check("mid_idle_busy", {31'd0, bus.busy}, 32'd0);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
